// File: rtl/dest_pop_arbiter_pkg.sv
// Shared types and constants for the destination pop arbiter.
package dest_pop_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 6;
    localparam int CNT_W_DEFAULT  = 8;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    // Round-robin pick between two requesters; returns {grant_d1, grant_d0}.
    // last_d1 set means D1 won the previous grant, so D0 wins a tie.
    function automatic logic [1:0] rr_pick(input logic elig_d0,
                                           input logic elig_d1,
                                           input logic last_d1);
        logic [1:0] g;
        g = 2'b00;
        if (elig_d0 && elig_d1) begin
            g = last_d1 ? 2'b01 : 2'b10;
        end else if (elig_d0) begin
            g = 2'b01;
        end else if (elig_d1) begin
            g = 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/dest_pop_arbiter_skid_buf2.sv
// Two-entry FIFO holding {dest, data} words; the head entry is a flop so
// the consumer sees a registered word.
module skid_buf2
    import dest_pop_arbiter_pkg::*;
#(
    parameter int W = DATA_W_DEFAULT + 1
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] entry0_q, entry0_d;
    logic [W-1:0] entry1_q, entry1_d;
    logic [1:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;

    // Pop first (shift entry1 forward), then place the pushed word in the
    // first free slot; a push into a full buffer with no pop is dropped.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (pop && (count_q != 2'd0)) begin
            entry0_d = entry1_q;
            count_d  = count_q - 2'd1;
        end
        if (push) begin
            if (count_d == 2'd0) begin
                entry0_d = din;
                count_d  = 2'd1;
            end else if (count_d == 2'd1) begin
                entry1_d = din;
                count_d  = 2'd2;
            end
        end
        full_d  = (count_d == 2'd2);
        empty_d = (count_d == 2'd0);
    end

    // Storage and status registers; buffer starts empty.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head  = entry0_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/dest_pop_arbiter.sv
// Drains destination FIFOs D0/D1 with round-robin pops, captures the
// returned words into a 2-entry buffer and streams them out with
// valid/ready, counting deliveries per destination.
module dest_pop_arbiter
    import dest_pop_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic              empty_D0,
    input  logic              empty_D1,
    input  logic [DATA_W-1:0] data_D0,
    input  logic [DATA_W-1:0] data_D1,
    input  logic              valid_D0,
    input  logic              valid_D1,
    input  logic              ready_out,
    output logic              pop_D0,
    output logic              pop_D1,
    output logic [DATA_W-1:0] data_out,
    output logic              dest_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  count_D0,
    output logic [CNT_W-1:0]  count_D1,
    output logic              err_unexp,
    output logic              err_ovf
);

    localparam int BUF_W = DATA_W + 1;

    state_t           state_q, state_d;
    logic             pop_d0_q, pop_d0_d;
    logic             pop_d1_q, pop_d1_d;
    logic             arrive_d0_q, arrive_d0_d;
    logic             arrive_d1_q, arrive_d1_d;
    logic             last_d1_q, last_d1_d;
    logic [CNT_W-1:0] count_d0_q, count_d0_d;
    logic [CNT_W-1:0] count_d1_q, count_d1_d;
    logic             err_unexp_q, err_unexp_d;
    logic             err_ovf_q, err_ovf_d;

    logic             buf_push, buf_pop, buf_full, buf_empty;
    logic [1:0]       buf_count;
    logic [BUF_W-1:0] buf_din, buf_head;

    logic             deliver;
    logic             keep_d0, keep_d1, unexp;
    logic [2:0]       occ_next, committed;
    logic             room, elig_d0, elig_d1;
    logic [1:0]       grant;

    skid_buf2 #(.W(BUF_W)) u_buf (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (buf_push),
        .pop     (buf_pop),
        .din     (buf_din),
        .head    (buf_head),
        .full    (buf_full),
        .empty   (buf_empty),
        .count   (buf_count)
    );

    // Capture only words that answer last cycle's pop; anything else is
    // flagged as unexpected and discarded.
    always_comb begin
        deliver     = !buf_empty && ready_out;
        keep_d0     = valid_D0 && arrive_d0_q;
        keep_d1     = valid_D1 && arrive_d1_q;
        unexp       = (valid_D0 && !arrive_d0_q) || (valid_D1 && !arrive_d1_q);
        buf_push    = keep_d0 || keep_d1;
        buf_pop     = deliver;
        buf_din     = keep_d1 ? {DEST_D1, data_D1} : {DEST_D0, data_D0};
        err_unexp_d = err_unexp_q || unexp;
        err_ovf_d   = err_ovf_q || (buf_push && buf_full && !deliver);
    end

    // Next-state logic: DRAIN finishes once nothing is outstanding.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (!pop_d0_q && !pop_d1_q && !arrive_d0_q &&
                             !arrive_d1_q && buf_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop decision for next cycle: reserve a buffer slot for every word
    // that will be in the buffer or on its way after this edge.
    always_comb begin
        occ_next    = {1'b0, buf_count} + {2'b00, buf_push} - {2'b00, deliver};
        committed   = occ_next + {2'b00, pop_d0_q} + {2'b00, pop_d1_q};
        room        = (committed < 3'd2);
        elig_d0     = (state_d == RUN) && !empty_D0 && !pop_d0_q && room;
        elig_d1     = (state_d == RUN) && !empty_D1 && !pop_d1_q && room;
        grant       = rr_pick(elig_d0, elig_d1, last_d1_q);
        pop_d0_d    = grant[0];
        pop_d1_d    = grant[1];
        last_d1_d   = last_d1_q;
        if (grant[1]) begin
            last_d1_d = 1'b1;
        end else if (grant[0]) begin
            last_d1_d = 1'b0;
        end
        arrive_d0_d = pop_d0_q;
        arrive_d1_d = pop_d1_q;
    end

    // Delivery counters, wrapping silently.
    always_comb begin
        count_d0_d = count_d0_q;
        count_d1_d = count_d1_q;
        if (deliver) begin
            if (buf_head[DATA_W] == DEST_D1) begin
                count_d1_d = count_d1_q + CNT_W'(1);
            end else begin
                count_d0_d = count_d0_q + CNT_W'(1);
            end
        end
    end

    // Control registers; the pointer resets to "D1 last" so D0 wins first.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            pop_d0_q    <= 1'b0;
            pop_d1_q    <= 1'b0;
            arrive_d0_q <= 1'b0;
            arrive_d1_q <= 1'b0;
            last_d1_q   <= 1'b1;
            count_d0_q  <= '0;
            count_d1_q  <= '0;
            err_unexp_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pop_d0_q    <= pop_d0_d;
            pop_d1_q    <= pop_d1_d;
            arrive_d0_q <= arrive_d0_d;
            arrive_d1_q <= arrive_d1_d;
            last_d1_q   <= last_d1_d;
            count_d0_q  <= count_d0_d;
            count_d1_q  <= count_d1_d;
            err_unexp_q <= err_unexp_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign pop_D0    = pop_d0_q;
    assign pop_D1    = pop_d1_q;
    assign data_out  = buf_head[DATA_W-1:0];
    assign dest_out  = buf_head[DATA_W];
    assign valid_out = !buf_empty;
    assign count_D0  = count_d0_q;
    assign count_D1  = count_d1_q;
    assign err_unexp = err_unexp_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_dest_pop_arbiter.sv
// Directed bench for dest_pop_arbiter with behavioural D0/D1 FIFO models.
module tb_dest_pop_arbiter;
    import dest_pop_arbiter_pkg::*;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk;
    logic          reset_L;
    logic          enable;
    logic          empty_D0, empty_D1;
    logic [DW-1:0] data_D0, data_D1;
    logic          valid_D0, valid_D1;
    logic          ready_out;
    logic          pop_D0, pop_D1;
    logic [DW-1:0] data_out;
    logic          dest_out;
    logic          valid_out;
    logic [CW-1:0] count_D0, count_D1;
    logic          err_unexp, err_ovf;

    int vectors;
    int miscompares;

    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:1023];
    logic [9:0]    head0, head1, tail0, tail1;
    logic          fv0, fv1, inj0, inj1;

    dest_pop_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .enable    (enable),
        .empty_D0  (empty_D0),
        .empty_D1  (empty_D1),
        .data_D0   (data_D0),
        .data_D1   (data_D1),
        .valid_D0  (valid_D0),
        .valid_D1  (valid_D1),
        .ready_out (ready_out),
        .pop_D0    (pop_D0),
        .pop_D1    (pop_D1),
        .data_out  (data_out),
        .dest_out  (dest_out),
        .valid_out (valid_out),
        .count_D0  (count_D0),
        .count_D1  (count_D1),
        .err_unexp (err_unexp),
        .err_ovf   (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign empty_D0 = (head0 == tail0);
    assign empty_D1 = (head1 == tail1);
    assign valid_D0 = fv0 | inj0;
    assign valid_D1 = fv1 | inj1;

    // FIFO models: read data and valid appear one cycle after a pop.
    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            head0 <= '0; head1 <= '0; fv0 <= 1'b0; fv1 <= 1'b0;
            data_D0 <= '0; data_D1 <= '0;
        end else begin
            fv0 <= 1'b0;
            fv1 <= 1'b0;
            if (pop_D0 && (head0 != tail0)) begin
                data_D0 <= mem0[head0]; head0 <= head0 + 10'd1; fv0 <= 1'b1;
            end
            if (pop_D1 && (head1 != tail1)) begin
                data_D1 <= mem1[head1]; head1 <= head1 + 10'd1; fv1 <= 1'b1;
            end
        end
    end

    task automatic load_d0(input logic [DW-1:0] w);
        mem0[tail0] = w;
        tail0 = tail0 + 10'd1;
    endtask

    task automatic load_d1(input logic [DW-1:0] w);
        mem1[tail1] = w;
        tail1 = tail1 + 10'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0; enable = 1'b0; ready_out = 1'b0;
        inj0 = 1'b0; inj1 = 1'b0; tail0 = '0; tail1 = '0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_L = 1'b0; enable = 1'b0; ready_out = 1'b0;
        inj0 = 1'b0; inj1 = 1'b0; tail0 = '0; tail1 = '0;
        #1;
        vectors++;
        if ({pop_D0, pop_D1, data_out, dest_out, valid_out, count_D0, count_D1, err_unexp, err_ovf} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got pop=%b%b data=%h dest=%b valid=%b c0=%0d c1=%0d eu=%b eo=%b expected all zero",
                     pop_D0, pop_D1, data_out, dest_out, valid_out, count_D0, count_D1, err_unexp, err_ovf);
        end
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        vectors++;
        if ({pop_D0, pop_D1, valid_out} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got pop=%b%b valid=%b expected 000", pop_D0, pop_D1, valid_out);
        end
    endtask

    task automatic test_single_d0();
        logic [9:0] exp_pop;
        logic [9:0] exp_val;
        int         widx;
        exp_pop = 10'b00_0010_1010;
        exp_val = 10'b00_1010_1000;
        widx    = 0;
        do_reset();
        load_d0(6'h01); load_d0(6'h02); load_d0(6'h03);
        ready_out = 1'b1;
        enable    = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            vectors++;
            if ({pop_D1, pop_D0, valid_out} !== {1'b0, exp_pop[k], exp_val[k]}) begin
                miscompares++;
                $display("[TB] FAIL single_d0_cycle%0d: got pop1=%b pop0=%b valid=%b expected pop1=0 pop0=%b valid=%b",
                         k, pop_D1, pop_D0, valid_out, exp_pop[k], exp_val[k]);
            end
            if (valid_out) begin
                widx++;
                vectors++;
                if ({dest_out, data_out} !== {1'b0, 6'(widx)}) begin
                    miscompares++;
                    $display("[TB] FAIL single_d0_word%0d: got dest=%b data=%h expected dest=0 data=%h",
                             widx, dest_out, data_out, 6'(widx));
                end
            end
        end
        vectors++;
        if (count_D0 !== 8'd3 || count_D1 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL single_d0_count: got c0=%0d c1=%0d expected 3 0", count_D0, count_D1);
        end
    endtask

    task automatic test_alternate();
        int         delivered;
        int         pops_seen;
        logic [1:0] exp_grant;
        logic       exp_dest;
        logic [5:0] exp_word;
        delivered = 0;
        pops_seen = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_d0(6'(6'h01 + i));
            load_d1(6'(6'h11 + i));
        end
        ready_out = 1'b1;
        enable    = 1'b1;
        for (int cyc = 0; cyc < 80 && delivered < 8; cyc++) begin
            @(negedge clk);
            if (pop_D0 || pop_D1) begin
                exp_grant = pops_seen[0] ? 2'b10 : 2'b01;
                vectors++;
                if ({pop_D1, pop_D0} !== exp_grant) begin
                    miscompares++;
                    $display("[TB] FAIL alt_grant%0d: got pop1/pop0=%b expected %b", pops_seen, {pop_D1, pop_D0}, exp_grant);
                end
                pops_seen++;
            end
            if (valid_out) begin
                exp_dest = delivered[0];
                exp_word = exp_dest ? 6'(6'h11 + delivered / 2) : 6'(6'h01 + delivered / 2);
                vectors++;
                if ({dest_out, data_out} !== {exp_dest, exp_word}) begin
                    miscompares++;
                    $display("[TB] FAIL alt_word%0d: got dest=%b data=%h expected dest=%b data=%h",
                             delivered, dest_out, data_out, exp_dest, exp_word);
                end
                delivered++;
            end
        end
        vectors++;
        if (delivered != 8) begin
            miscompares++;
            $display("[TB] FAIL alt_timeout: got %0d deliveries expected 8", delivered);
        end
        @(negedge clk);
        vectors++;
        if (count_D0 !== 8'd4 || count_D1 !== 8'd4) begin
            miscompares++;
            $display("[TB] FAIL alt_counts: got c0=%0d c1=%0d expected 4 4", count_D0, count_D1);
        end
    endtask

    task automatic test_backpressure();
        int         pops;
        logic       seen;
        logic       moved;
        logic [6:0] held;
        pops  = 0;
        seen  = 1'b0;
        moved = 1'b0;
        held  = '0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_d0(6'(6'h01 + i));
            load_d1(6'(6'h11 + i));
        end
        ready_out = 1'b0;
        enable    = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            pops = pops + int'(pop_D0) + int'(pop_D1);
            if (valid_out) begin
                if (!seen) begin
                    held = {dest_out, data_out};
                    seen = 1'b1;
                end else if ({dest_out, data_out} !== held) begin
                    moved = 1'b1;
                end
            end
        end
        vectors++;
        if (pops != 2) begin
            miscompares++;
            $display("[TB] FAIL bp_pops: got %0d pops expected 2", pops);
        end
        vectors++;
        if (valid_out !== 1'b1 || {dest_out, data_out} !== {1'b0, 6'h01}) begin
            miscompares++;
            $display("[TB] FAIL bp_head: got valid=%b dest=%b data=%h expected valid=1 dest=0 data=01", valid_out, dest_out, data_out);
        end
        vectors++;
        if (moved !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_stable: got head changed=%b expected 0", moved);
        end
        vectors++;
        if (err_ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_err_ovf: got %b expected 0", err_ovf);
        end
        ready_out = 1'b1;
        @(negedge clk);
        vectors++;
        if (valid_out !== 1'b1 || {dest_out, data_out} !== {1'b1, 6'h11}) begin
            miscompares++;
            $display("[TB] FAIL bp_second: got valid=%b dest=%b data=%h expected valid=1 dest=1 data=11", valid_out, dest_out, data_out);
        end
    endtask

    task automatic test_enable_drop();
        int extra_pops;
        int delivered;
        extra_pops = 0;
        delivered  = 0;
        do_reset();
        load_d1(6'h15); load_d1(6'h16); load_d1(6'h17);
        ready_out = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        vectors++;
        if ({pop_D1, pop_D0} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL drop_first_pop: got pop1/pop0=%b expected 10", {pop_D1, pop_D0});
        end
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) enable = 1'b0;
            extra_pops = extra_pops + int'(pop_D0) + int'(pop_D1);
            if (valid_out) begin
                delivered++;
                vectors++;
                if ({dest_out, data_out} !== {1'b1, 6'h15}) begin
                    miscompares++;
                    $display("[TB] FAIL drop_word: got dest=%b data=%h expected dest=1 data=15", dest_out, data_out);
                end
            end
        end
        vectors++;
        if (extra_pops != 0 || delivered != 1) begin
            miscompares++;
            $display("[TB] FAIL drop_activity: got pops=%0d delivered=%0d expected 0 1", extra_pops, delivered);
        end
        vectors++;
        if (count_D1 !== 8'd1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_count: got c1=%0d valid=%b expected 1 0", count_D1, valid_out);
        end
        vectors++;
        if (dut.state_q !== IDLE) begin
            miscompares++;
            $display("[TB] FAIL drop_state: got %0d expected %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        vectors++;
        if (err_unexp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL unexp_pre: got %b expected 0", err_unexp);
        end
        inj0 = 1'b1;
        @(negedge clk);
        inj0 = 1'b0;
        vectors++;
        if (err_unexp !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL unexp_set: got %b expected 1", err_unexp);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (err_unexp !== 1'b1 || err_ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL unexp_sticky: got eu=%b eo=%b expected 1 0", err_unexp, err_ovf);
        end
        reset_L = 1'b0;
        #1;
        vectors++;
        if (err_unexp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL unexp_clear: got %b expected 0", err_unexp);
        end
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_wrap();
        int         delivered;
        logic       checked;
        logic [8:0] iv;
        logic [5:0] exp_word;
        delivered = 0;
        checked   = 1'b0;
        do_reset();
        for (int i = 0; i < 257; i++) begin
            iv = 9'(i);
            load_d1({iv[4], 1'b1, iv[3:0]});
        end
        ready_out = 1'b1;
        enable    = 1'b1;
        for (int cyc = 0; cyc < 2000 && delivered < 257; cyc++) begin
            @(negedge clk);
            if (delivered == 256 && !checked) begin
                checked = 1'b1;
                vectors++;
                if (count_D1 !== 8'd0) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_zero: got c1=%0d expected 0", count_D1);
                end
            end
            if (valid_out) begin
                iv = 9'(delivered);
                exp_word = {iv[4], 1'b1, iv[3:0]};
                vectors++;
                if ({dest_out, data_out} !== {1'b1, exp_word}) begin
                    miscompares++;
                    $display("[TB] FAIL wrap_word%0d: got dest=%b data=%h expected dest=1 data=%h",
                             delivered, dest_out, data_out, exp_word);
                end
                delivered++;
            end
        end
        vectors++;
        if (delivered != 257) begin
            miscompares++;
            $display("[TB] FAIL wrap_timeout: got %0d deliveries expected 257", delivered);
        end
        @(negedge clk);
        vectors++;
        if (count_D1 !== 8'd1 || count_D0 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_count: got c1=%0d c0=%0d expected 1 0", count_D1, count_D0);
        end
        reset_L = 1'b0;
        #1;
        vectors++;
        if (count_D1 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_reset_clear: got c1=%0d expected 0", count_D1);
        end
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    // Sequence every scenario, then report the totals.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_L     = 1'b1;
        enable      = 1'b0;
        ready_out   = 1'b0;
        inj0        = 1'b0;
        inj1        = 1'b0;
        tail0       = '0;
        tail1       = '0;
        test_reset();
        test_single_d0();
        test_alternate();
        test_backpressure();
        test_enable_drop();
        test_unexpected();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
